// File: rtl/opl3_pkg.sv
// Shared types and constants for the OPL3 host write path.
// Defines the register-write bus layout and the host port encodings.
package opl3_pkg;

    localparam int REG_FILE_DATA_WIDTH = 8;

    localparam logic HOST_PORT_ADDR = 1'b0;
    localparam logic HOST_PORT_DATA = 1'b1;

    typedef struct packed {
        logic                           valid;
        logic                           bank_num;
        logic [7:0]                     address;
        logic [REG_FILE_DATA_WIDTH-1:0] data;
    } opl3_reg_wr_t;

    // Queued entries carry everything except the valid bit.
    localparam int REG_ENTRY_WIDTH = $bits(opl3_reg_wr_t) - 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_STROBE,
        ST_GAP
    } wr_state_e;

endpackage

// File: rtl/opl3_wr_fifo.sv
// Small synchronous FIFO holding pending OPL3 register writes.
// Push is ignored when full and pop is ignored when empty.
module opl3_wr_fifo
    import opl3_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = REG_ENTRY_WIDTH
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign level   = wr_ptr - rd_ptr;
    assign full    = (level == (AW+1)'(DEPTH));
    assign empty   = (wr_ptr == rd_ptr);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/opl3_host_if.sv
// Host-side write port for the OPL3 core: latches address/bank, queues data writes,
// and replays them as single-cycle opl3_reg_wr strobes separated by MIN_WR_GAP idle clocks.
module opl3_host_if
    import opl3_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int MIN_WR_GAP = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          host_valid,
    output logic                          host_ready,
    input  logic [1:0]                    host_a,
    input  logic [7:0]                    host_din,
    output logic [17:0]                   opl3_reg_wr,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int GW = $clog2(MIN_WR_GAP + 2);

    logic [7:0]                 addr_q;
    logic                       bank_q;
    opl3_reg_wr_t               wr_q;
    wr_state_e                  state;
    logic [GW-1:0]              gap_cnt;

    logic                       fifo_full;
    logic                       fifo_empty;
    logic                       accept;
    logic                       push;
    logic                       launch;
    logic [REG_ENTRY_WIDTH-1:0] fifo_din;
    logic [REG_ENTRY_WIDTH-1:0] fifo_dout;

    assign host_ready = !fifo_full;
    assign accept     = host_valid && host_ready;
    assign push       = accept && (host_a[0] == HOST_PORT_DATA);
    assign fifo_din   = {bank_q, addr_q, host_din};

    // A new strobe may start from IDLE, straight out of STROBE when no gap is
    // configured, or on the last GAP cycle so spacing is exactly MIN_WR_GAP.
    assign launch = !fifo_empty &&
                    ((state == ST_IDLE) ||
                     ((state == ST_STROBE) && (MIN_WR_GAP == 0)) ||
                     ((state == ST_GAP) && (gap_cnt <= GW'(1))));

    opl3_wr_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (REG_ENTRY_WIDTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .din   (fifo_din),
        .pop   (launch),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q <= 8'h00;
            bank_q <= 1'b0;
        end else if (accept && (host_a[0] == HOST_PORT_ADDR)) begin
            addr_q <= host_din;
            bank_q <= host_a[1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            wr_q    <= '0;
            gap_cnt <= '0;
        end else if (launch) begin
            wr_q    <= {1'b1, fifo_dout};
            state   <= ST_STROBE;
        end else begin
            case (state)
                ST_IDLE: begin
                    state <= ST_IDLE;
                end
                ST_STROBE: begin
                    wr_q.valid <= 1'b0;
                    if (MIN_WR_GAP == 0) begin
                        state <= ST_IDLE;
                    end else begin
                        state   <= ST_GAP;
                        gap_cnt <= GW'(MIN_WR_GAP);
                    end
                end
                ST_GAP: begin
                    if (gap_cnt <= GW'(1)) begin
                        state <= ST_IDLE;
                    end else begin
                        gap_cnt <= gap_cnt - 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign opl3_reg_wr = wr_q;
    assign busy        = !fifo_empty || (state != ST_IDLE);

endmodule

// File: tb/tb_opl3_host_if.sv
// Scoreboard bench for opl3_host_if: one instance with a 2-cycle gap, one with no gap.
// Drivers push hand-computed strobe values; per-instance monitors pop and compare.
module tb_opl3_host_if;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;

    logic        a_valid, a_ready, a_busy;
    logic [1:0]  a_a;
    logic [7:0]  a_din;
    logic [17:0] a_wr;
    logic [2:0]  a_level;

    logic        b_valid, b_ready, b_busy;
    logic [1:0]  b_a;
    logic [7:0]  b_din;
    logic [17:0] b_wr;
    logic [2:0]  b_level;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          hs_cyc = 0;
    int          notready_a = 0;
    bit          prev_a = 1'b0;

    logic [17:0] exp_a[$];
    logic [17:0] exp_b[$];
    int          stb_a[$];
    int          stb_b[$];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    opl3_host_if #(.FIFO_DEPTH(4), .MIN_WR_GAP(2)) dut_a (
        .clk         (clk),
        .rst_n       (rst_n),
        .host_valid  (a_valid),
        .host_ready  (a_ready),
        .host_a      (a_a),
        .host_din    (a_din),
        .opl3_reg_wr (a_wr),
        .busy        (a_busy),
        .fifo_level  (a_level)
    );

    opl3_host_if #(.FIFO_DEPTH(4), .MIN_WR_GAP(0)) dut_b (
        .clk         (clk),
        .rst_n       (rst_n),
        .host_valid  (b_valid),
        .host_ready  (b_ready),
        .host_a      (b_a),
        .host_din    (b_din),
        .opl3_reg_wr (b_wr),
        .busy        (b_busy),
        .fifo_level  (b_level)
    );

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Drive one host write starting at a negedge; data writes queue their expected strobe.
    task automatic apply_stimulus(input int sel, input logic [1:0] port, input logic [7:0] din,
                                  input logic [17:0] exp);
        int   tries = 0;
        logic rdy;
        if (sel == 0) begin a_valid = 1'b1; a_a = port; a_din = din; end
        else          begin b_valid = 1'b1; b_a = port; b_din = din; end
        rdy = (sel == 0) ? a_ready : b_ready;
        while (!rdy && tries < 100) begin
            @(negedge clk);
            tries++;
            rdy = (sel == 0) ? a_ready : b_ready;
        end
        if (!rdy) begin
            check_output("handshake_timeout", 32'd0, 32'd1);
        end else begin
            @(posedge clk);
            if (port[0]) begin
                if (sel == 0) exp_a.push_back(exp);
                else          exp_b.push_back(exp);
            end
            @(negedge clk);
            hs_cyc = cyc;
        end
        if (sel == 0) a_valid = 1'b0;
        else          b_valid = 1'b0;
    endtask

    task automatic wait_idle(input int sel);
        int n = 0;
        while (n < 200 && !((sel == 0) ? (exp_a.size() == 0 && !a_busy)
                                       : (exp_b.size() == 0 && !b_busy))) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) check_output("drain_timeout", 32'd0, 32'd1);
    endtask

    always @(negedge clk) begin : mon_a
        logic [17:0] e;
        if (!rst_n) begin
            prev_a <= 1'b0;
        end else begin
            if (!a_ready) notready_a <= notready_a + 1;
            if (a_wr[17]) begin
                stb_a.push_back(cyc);
                if (exp_a.size() == 0) begin
                    check_output("unexpected_strobe_a", a_wr, 32'd0);
                end else begin
                    e = exp_a.pop_front();
                    check_output("strobe_a", a_wr, e);
                end
                check_output("strobe_width_a", prev_a, 32'd0);
            end
            prev_a <= a_wr[17];
        end
    end

    always @(negedge clk) begin : mon_b
        logic [17:0] e;
        if (rst_n && b_wr[17]) begin
            stb_b.push_back(cyc);
            if (exp_b.size() == 0) begin
                check_output("unexpected_strobe_b", b_wr, 32'd0);
            end else begin
                e = exp_b.pop_front();
                check_output("strobe_b", b_wr, e);
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int nr_before;
        a_valid = 1'b0; a_a = 2'b00; a_din = 8'h00;
        b_valid = 1'b0; b_a = 2'b00; b_din = 8'h00;
        #2 rst_n = 1'b0;
        #1;
        check_output("reset_reg_wr", a_wr, 32'h0);
        check_output("reset_busy", a_busy, 32'h0);
        check_output("reset_level", a_level, 32'h0);
        check_output("reset_ready", a_ready, 32'h1);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Data write with no prior address write uses bank 0, address 0x00.
        stb_a.delete();
        apply_stimulus(0, 2'b01, 8'h55, 18'h20055);
        wait_idle(0);
        check_output("no_addr_count", stb_a.size(), 32'd1);

        // Single write: strobe appears one cycle after the data handshake.
        apply_stimulus(0, 2'b00, 8'hB0, 18'h0);
        stb_a.delete();
        apply_stimulus(0, 2'b01, 8'h20, 18'h2B020);
        wait_idle(0);
        check_output("single_count", stb_a.size(), 32'd1);
        if (stb_a.size() == 1) check_output("single_latency", stb_a[0] - hs_cyc, 32'd1);

        // Bank comes from the address write, never from host_a[1] on a data write.
        apply_stimulus(0, 2'b10, 8'h05, 18'h0);
        apply_stimulus(0, 2'b01, 8'h01, 18'h30501);
        apply_stimulus(0, 2'b00, 8'h06, 18'h0);
        apply_stimulus(0, 2'b11, 8'h7F, 18'h2067F);
        wait_idle(0);

        // Six back-to-back data writes fill the FIFO; strobes stay in order, 3 cycles apart.
        apply_stimulus(0, 2'b00, 8'h40, 18'h0);
        stb_a.delete();
        nr_before = notready_a;
        for (int i = 0; i < 6; i++) begin
            apply_stimulus(0, 2'b01, 8'h10 + 8'(i), {2'b10, 8'h40, 8'h10 + 8'(i)});
        end
        wait_idle(0);
        check_output("ready_dropped", (notready_a != nr_before), 32'd1);
        check_output("burst_count", stb_a.size(), 32'd6);
        if (stb_a.size() == 6) begin
            for (int i = 1; i < 6; i++) check_output("burst_spacing", stb_a[i] - stb_a[i-1], 32'd3);
        end

        // No gap configured: three queued writes strobe on consecutive cycles.
        apply_stimulus(1, 2'b00, 8'h60, 18'h0);
        stb_b.delete();
        for (int i = 0; i < 3; i++) begin
            apply_stimulus(1, 2'b01, 8'hA0 + 8'(i), {2'b10, 8'h60, 8'hA0 + 8'(i)});
        end
        wait_idle(1);
        check_output("nogap_count", stb_b.size(), 32'd3);
        if (stb_b.size() == 3) begin
            for (int i = 1; i < 3; i++) check_output("nogap_spacing", stb_b[i] - stb_b[i-1], 32'd1);
        end

        // Reset mid-gap with three entries queued drops everything.
        apply_stimulus(0, 2'b00, 8'h22, 18'h0);
        for (int i = 0; i < 4; i++) begin
            apply_stimulus(0, 2'b01, 8'h31 + 8'(i), {2'b10, 8'h22, 8'h31 + 8'(i)});
        end
        check_output("pre_reset_level", a_level, 32'd3);
        check_output("pre_reset_valid", a_wr[17], 32'd0);
        check_output("pre_reset_busy", a_busy, 32'd1);
        rst_n = 1'b0;
        #1;
        check_output("midreset_reg_wr", a_wr, 32'h0);
        check_output("midreset_busy", a_busy, 32'h0);
        check_output("midreset_level", a_level, 32'h0);
        check_output("midreset_ready", a_ready, 32'h1);
        exp_a.delete();
        stb_a.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (15) @(negedge clk);
        check_output("post_reset_strobes", stb_a.size(), 32'd0);
        check_output("post_reset_busy", a_busy, 32'd0);

        // Address latch is cleared by reset.
        apply_stimulus(0, 2'b01, 8'h55, 18'h20055);
        wait_idle(0);

        check_output("leftover_a", exp_a.size(), 32'd0);
        check_output("leftover_b", exp_b.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
